alu_seq_control: RTL and testbench
==================================

Name: alu_seq_control

Overview:
- Hardwired control unit that sequences the single-bus datapath through fetch and execute.
- Drives every datapath enable, the bus source select, the register-file address and the ALU opcode from a T-state machine.
- Consumes the IR word and a memory-ready strobe.
- Covers three-register ALU instructions, MUL/DIV (HI/LO writeback), NOP and HALT.
- Illegal opcodes park the unit in a sticky fault state.

Parameters:
COUNT_W, 16, width of retired-instruction counter (wraps modulo 2^COUNT_W)
FAULT_ON_ILLEGAL, 1, 1: illegal opcode enters FAULT; 0: treated as NOP

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
run  input  1  level; 1 permits fetching, 0 stops at next instruction boundary
mem_ready  input  1  memory data valid on Mdatain this cycle
IR  input  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, MDR_read  output  1 each  datapath enables
GP_addr  output  4  register-file select
BusDataSelect  output  5  bus source: 0-15 R0-R15, 16 HI, 17 LO, 18 Z_HI, 19 Z_LO, 20 PC, 21 MDR
ALU_op  output  4  ALU operation
halted  output  1  high in HALT
fault  output  1  high in FAULT
instr_count  output  COUNT_W  retired instructions

Behaviour:
- Reset (clear=1, async):
  - state=IDLE; all enables 0; GP_addr=0; BusDataSelect=0; ALU_op=0; instr_count=0; halted=0; fault=0.
  - clear mid-instruction aborts immediately; no partial writeback enable survives.
- Outputs are Moore decodes of the registered state (plus registered IR fields). Each enable is high for exactly one cycle per state; the datapath captures on the following rising edge.
- States and outputs:
  - IDLE: all enables 0. Go to T0 when run=1.
  - T0: BusDataSelect=20, e_MAR=1, incPC=1, e_Z=1. Go to T1.
  - T1: BusDataSelect=19, e_PC=1, MDR_read=1, e_MDR=1. If mem_ready=1, go to T2; else go to T1W.
  - T1W: MDR_read=1, e_MDR=1, e_PC=0. Stay until mem_ready=1, then go to T2.
  - T2: BusDataSelect=21, e_IR=1. Go to T3.
  - T3 (decode valid; IR latched at end of T2):
    - ALU/MUL/DIV: BusDataSelect=Rb, GP_addr=Rb, e_Y=1; go to T4.
    - NOP: no enables; retire; go to T0 if run=1, else IDLE.
    - HALT: go to HALT.
    - Illegal: go to FAULT.
  - T4: BusDataSelect=Rc, GP_addr=Rc, ALU_op=opcode-derived, e_Z=1. Go to T5.
  - T5:
    - ALU: BusDataSelect=19, GP_addr=Ra, e_GP=1; retire.
    - MUL/DIV: BusDataSelect=19, e_LO=1; go to T6.
  - T6 (MUL/DIV only): BusDataSelect=18, e_HI=1; retire.
  - HALT: halted=1. Exit to T0 only on run 0->1 (edge-detected register); a run level held high does not exit.
  - FAULT: fault=1. Sticky; only clear exits.
- Retire means: instr_count increments by 1 (wraps to 0), then go to T0 if run=1, else IDLE.
- run is sampled only at retire and in IDLE/HALT. Deasserting run mid-instruction does not shorten the instruction.
- Opcode map:
  - 0x00-0x09 ALU: ALU_op=opcode[3:0] (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 XOR).
  - 0x0A MUL: ALU_op=4'hA.
  - 0x0B DIV: ALU_op=4'hB.
  - 0x1E NOP.
  - 0x1F HALT.
  - Others illegal.
- ALU_op holds its last driven value outside T4. GP_addr and BusDataSelect read 0 in states that do not use them.
- Ra=R0 writeback is permitted; there is no special case.
- mem_ready=1 already in T1 means no wait state: fetch takes 3 cycles. Each wait cycle adds 1.
- Latency with mem_ready=1 in T1: ALU instruction 6 cycles (T0-T5), MUL/DIV 7, NOP 4.

Test Plan:
- Reset/idle: clear=1 then 0, run=0 for 10 cycles -> all enables 0, state IDLE, instr_count=0.
- ADD, no wait: IR=0x00B48000 (Ra=1, Rb=6, Rc=9), mem_ready=1 -> T3 BusDataSelect=6 e_Y=1; T4 BusDataSelect=9 ALU_op=0 e_Z=1; T5 BusDataSelect=19 GP_addr=1 e_GP=1; instr_count=1 after 6 cycles.
- Wait states + SHL: mem_ready low for 3 cycles in T1/T1W, opcode 0x06 -> e_PC high only once; MDR_read held 4 cycles; ALU_op=6 in T4; total 9 cycles.
- MUL: opcode 0x0A -> T5 e_LO=1 BusDataSelect=19, T6 e_HI=1 BusDataSelect=18, no e_GP; instr_count+1.
- HALT/restart and run drop: HALT -> halted=1 with run held 1; run 0->1 -> T0. Run dropped during T4 of an ADD -> writeback completes, then IDLE.
- Illegal and reset mid-op: opcode 0x15 -> fault=1 sticky, no e_GP. clear pulsed during T4 -> all outputs 0 immediately, instr_count=0.

Source files
------------

// File: rtl/alu_seq_control.sv
// Hardwired T-state sequencer for the single-bus datapath: fetch (T0-T2), decode (T3),
// execute (T4-T6) with HI/LO writeback for MUL/DIV, plus HALT and sticky FAULT.
module alu_seq_control #(
    parameter int COUNT_W          = 16,
    parameter bit FAULT_ON_ILLEGAL = 1'b1
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               run,
    input  logic               mem_ready,
    input  logic [31:0]        IR,
    output logic               incPC,
    output logic               e_PC,
    output logic               e_IR,
    output logic               e_Y,
    output logic               e_Z,
    output logic               e_HI,
    output logic               e_LO,
    output logic               e_MDR,
    output logic               e_MAR,
    output logic               e_GP,
    output logic               MDR_read,
    output logic [3:0]         GP_addr,
    output logic [4:0]         BusDataSelect,
    output logic [3:0]         ALU_op,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
    } state_t;

    localparam logic [4:0] SEL_ZHI = 5'd18;
    localparam logic [4:0] SEL_ZLO = 5'd19;
    localparam logic [4:0] SEL_PC  = 5'd20;
    localparam logic [4:0] SEL_MDR = 5'd21;

    state_t             state, state_nx;
    logic               run_q;
    logic [3:0]         ra_q, rc_q, alu_op_q;
    logic               muldiv_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               retire;

    // IR is the datapath's own register, valid from T3 onward
    logic [4:0] op;
    logic       is_alu, is_md, is_nop, is_halt, is_exec;
    assign op      = IR[31:27];
    assign is_alu  = (op <= 5'h09);
    assign is_md   = (op == 5'h0A) || (op == 5'h0B);
    assign is_nop  = (op == 5'h1E);
    assign is_halt = (op == 5'h1F);
    assign is_exec = is_alu || is_md;

    logic unused_ir;
    assign unused_ir = ^IR[14:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_IDLE;
            run_q    <= 1'b0;
            ra_q     <= '0;
            rc_q     <= '0;
            muldiv_q <= 1'b0;
            alu_op_q <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_nx;
            run_q <= run;
            if (state == S_T3) begin
                ra_q     <= IR[26:23];
                rc_q     <= IR[18:15];
                muldiv_q <= is_md;
                if (is_exec) alu_op_q <= op[3:0];
            end
            if (retire) cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    always_comb begin
        state_nx      = state;
        retire        = 1'b0;
        incPC         = 1'b0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_HI          = 1'b0;
        e_LO          = 1'b0;
        e_MDR         = 1'b0;
        e_MAR         = 1'b0;
        e_GP          = 1'b0;
        MDR_read      = 1'b0;
        GP_addr       = 4'd0;
        BusDataSelect = 5'd0;
        halted        = 1'b0;
        fault         = 1'b0;
        case (state)
            S_IDLE: if (run) state_nx = S_T0;
            S_T0: begin
                BusDataSelect = SEL_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
                state_nx      = S_T1;
            end
            S_T1: begin
                BusDataSelect = SEL_ZLO;
                e_PC          = 1'b1;
                MDR_read      = 1'b1;
                e_MDR         = 1'b1;
                state_nx      = mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                MDR_read = 1'b1;
                e_MDR    = 1'b1;
                if (mem_ready) state_nx = S_T2;
            end
            S_T2: begin
                BusDataSelect = SEL_MDR;
                e_IR          = 1'b1;
                state_nx      = S_T3;
            end
            S_T3: begin
                if (is_exec) begin
                    BusDataSelect = {1'b0, IR[22:19]};
                    GP_addr       = IR[22:19];
                    e_Y           = 1'b1;
                    state_nx      = S_T4;
                end else if (is_halt) begin
                    state_nx = S_HALT;
                end else if (is_nop || !FAULT_ON_ILLEGAL) begin
                    retire = 1'b1;
                end else begin
                    state_nx = S_FAULT;
                end
            end
            S_T4: begin
                BusDataSelect = {1'b0, rc_q};
                GP_addr       = rc_q;
                e_Z           = 1'b1;
                state_nx      = S_T5;
            end
            S_T5: begin
                BusDataSelect = SEL_ZLO;
                if (muldiv_q) begin
                    e_LO     = 1'b1;
                    state_nx = S_T6;
                end else begin
                    GP_addr = ra_q;
                    e_GP    = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_T6: begin
                BusDataSelect = SEL_ZHI;
                e_HI          = 1'b1;
                retire        = 1'b1;
            end
            // only a fresh rising edge of run restarts; a held level does not
            S_HALT: begin
                halted = 1'b1;
                if (run && !run_q) state_nx = S_T0;
            end
            S_FAULT: fault = 1'b1;
            default: state_nx = S_IDLE;
        endcase
        if (retire) state_nx = run ? S_T0 : S_IDLE;
    end

    assign ALU_op      = alu_op_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_alu_seq_control.sv
// Directed per-cycle vector table for alu_seq_control, plus a narrow-counter instance
// exercising wrap-around, illegal-as-NOP and a mid-cycle asynchronous clear.
module tb_alu_seq_control;
    typedef struct {
        logic        clr, run, mrdy;
        logic [31:0] ir;
        logic [10:0] en;
        logic [3:0]  gp;
        logic [4:0]  bds;
        logic [3:0]  aop;
        logic        h, f;
        logic [15:0] cnt;
    } vec_t;

    // enable order: incPC e_PC e_IR e_Y e_Z e_HI e_LO e_MDR e_MAR e_GP MDR_read
    localparam logic [10:0] EN0    = 11'b000_0000_0000;
    localparam logic [10:0] EN_T0  = 11'b100_0100_0100;
    localparam logic [10:0] EN_T1  = 11'b010_0000_1001;
    localparam logic [10:0] EN_T1W = 11'b000_0000_1001;
    localparam logic [10:0] EN_T2  = 11'b001_0000_0000;
    localparam logic [10:0] EN_T3  = 11'b000_1000_0000;
    localparam logic [10:0] EN_T4  = 11'b000_0100_0000;
    localparam logic [10:0] EN_T5A = 11'b000_0000_0010;
    localparam logic [10:0] EN_T5M = 11'b000_0001_0000;
    localparam logic [10:0] EN_T6  = 11'b000_0010_0000;

    localparam logic [31:0] IR_ADD = 32'h00B4_8000;
    localparam logic [31:0] IR_SHL = {5'd6, 4'd2, 4'd3, 4'd4, 15'd0};
    localparam logic [31:0] IR_MUL = {5'h0A, 4'd5, 4'd7, 4'd8, 15'd0};
    localparam logic [31:0] IR_SUB = {5'd1, 4'd0, 4'd2, 4'd3, 15'd0};
    localparam logic [31:0] IR_HLT = 32'hF800_0000;
    localparam logic [31:0] IR_NOP = 32'hF000_0000;
    localparam logic [31:0] IR_ILL = 32'hA800_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear, run, mem_ready;
    logic [31:0] IR;
    logic incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, MDR_read;
    logic [3:0]  GP_addr, ALU_op;
    logic [4:0]  BusDataSelect;
    logic        halted, fault;
    logic [15:0] instr_count;

    alu_seq_control dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
        .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
        .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .MDR_read(MDR_read),
        .GP_addr(GP_addr), .BusDataSelect(BusDataSelect), .ALU_op(ALU_op),
        .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    logic        clear2, run2, mem_ready2;
    logic [31:0] IR2;
    logic [10:0] en2;
    logic [3:0]  GP_addr2, ALU_op2;
    logic [4:0]  BusDataSelect2;
    logic        halted2, fault2;
    logic [1:0]  instr_count2;

    alu_seq_control #(.COUNT_W(2), .FAULT_ON_ILLEGAL(1'b0)) dut2 (
        .clock(clock), .clear(clear2), .run(run2), .mem_ready(mem_ready2), .IR(IR2),
        .incPC(en2[10]), .e_PC(en2[9]), .e_IR(en2[8]), .e_Y(en2[7]), .e_Z(en2[6]),
        .e_HI(en2[5]), .e_LO(en2[4]), .e_MDR(en2[3]), .e_MAR(en2[2]), .e_GP(en2[1]),
        .MDR_read(en2[0]), .GP_addr(GP_addr2), .BusDataSelect(BusDataSelect2),
        .ALU_op(ALU_op2), .halted(halted2), .fault(fault2), .instr_count(instr_count2)
    );

    logic [10:0] en_bus;
    assign en_bus = {incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, MDR_read};

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic c, r, m, input logic [31:0] ir,
                                input logic [10:0] en, input logic [3:0] gp,
                                input logic [4:0] bds, input logic [3:0] aop,
                                input logic h, f, input logic [15:0] cnt);
        vec_t v;
        v.clr = c; v.run = r; v.mrdy = m; v.ir = ir; v.en = en; v.gp = gp;
        v.bds = bds; v.aop = aop; v.h = h; v.f = f; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; IR = '0;
        clear2 = 1'b1; run2 = 1'b0; mem_ready2 = 1'b1; IR2 = '0;

        for (int i = 0; i < 10; i++) add(0,0,1,0,      EN0,   0, 0, 0,0,0,0);
        // ADD R1 <- R6 + R9, run dropped at retire
        add(0,1,1,IR_ADD, EN0,   0, 0, 0,0,0,0);
        add(0,1,1,IR_ADD, EN_T0, 0,20, 0,0,0,0);
        add(0,1,1,IR_ADD, EN_T1, 0,19, 0,0,0,0);
        add(0,1,1,IR_ADD, EN_T2, 0,21, 0,0,0,0);
        add(0,1,1,IR_ADD, EN_T3, 6, 6, 0,0,0,0);
        add(0,1,1,IR_ADD, EN_T4, 9, 9, 0,0,0,0);
        add(0,0,1,IR_ADD, EN_T5A,1,19, 0,0,0,0);
        add(0,0,1,IR_ADD, EN0,   0, 0, 0,0,0,1);
        // SHL with three wait cycles
        add(0,1,1,IR_SHL, EN0,   0, 0, 0,0,0,1);
        add(0,1,1,IR_SHL, EN_T0, 0,20, 0,0,0,1);
        add(0,1,0,IR_SHL, EN_T1, 0,19, 0,0,0,1);
        add(0,1,0,IR_SHL, EN_T1W,0, 0, 0,0,0,1);
        add(0,1,0,IR_SHL, EN_T1W,0, 0, 0,0,0,1);
        add(0,1,1,IR_SHL, EN_T1W,0, 0, 0,0,0,1);
        add(0,1,1,IR_SHL, EN_T2, 0,21, 0,0,0,1);
        add(0,1,1,IR_SHL, EN_T3, 3, 3, 0,0,0,1);
        add(0,1,1,IR_SHL, EN_T4, 4, 4, 6,0,0,1);
        add(0,1,1,IR_SHL, EN_T5A,2,19, 6,0,0,1);
        // MUL back-to-back
        add(0,1,1,IR_MUL, EN_T0, 0,20, 6,0,0,2);
        add(0,1,1,IR_MUL, EN_T1, 0,19, 6,0,0,2);
        add(0,1,1,IR_MUL, EN_T2, 0,21, 6,0,0,2);
        add(0,1,1,IR_MUL, EN_T3, 7, 7, 6,0,0,2);
        add(0,1,1,IR_MUL, EN_T4, 8, 8,10,0,0,2);
        add(0,1,1,IR_MUL, EN_T5M,0,19,10,0,0,2);
        add(0,1,1,IR_MUL, EN_T6, 0,18,10,0,0,2);
        // HALT, held run does not exit, 0->1 restarts
        add(0,1,1,IR_HLT, EN_T0, 0,20,10,0,0,3);
        add(0,1,1,IR_HLT, EN_T1, 0,19,10,0,0,3);
        add(0,1,1,IR_HLT, EN_T2, 0,21,10,0,0,3);
        add(0,1,1,IR_HLT, EN0,   0, 0,10,0,0,3);
        add(0,1,1,IR_HLT, EN0,   0, 0,10,1,0,3);
        add(0,1,1,IR_HLT, EN0,   0, 0,10,1,0,3);
        add(0,0,1,IR_HLT, EN0,   0, 0,10,1,0,3);
        add(0,1,1,IR_NOP, EN0,   0, 0,10,1,0,3);
        // NOP retires from T3
        add(0,1,1,IR_NOP, EN_T0, 0,20,10,0,0,3);
        add(0,1,1,IR_NOP, EN_T1, 0,19,10,0,0,3);
        add(0,1,1,IR_NOP, EN_T2, 0,21,10,0,0,3);
        add(0,1,1,IR_NOP, EN0,   0, 0,10,0,0,3);
        // SUB into R0, run dropped in T4 still completes
        add(0,1,1,IR_SUB, EN_T0, 0,20,10,0,0,4);
        add(0,1,1,IR_SUB, EN_T1, 0,19,10,0,0,4);
        add(0,1,1,IR_SUB, EN_T2, 0,21,10,0,0,4);
        add(0,1,1,IR_SUB, EN_T3, 2, 2,10,0,0,4);
        add(0,0,1,IR_SUB, EN_T4, 3, 3, 1,0,0,4);
        add(0,0,1,IR_SUB, EN_T5A,0,19, 1,0,0,4);
        add(0,0,1,IR_SUB, EN0,   0, 0, 1,0,0,5);
        // illegal opcode 0x15 -> sticky FAULT
        add(0,1,1,IR_ILL, EN0,   0, 0, 1,0,0,5);
        add(0,1,1,IR_ILL, EN_T0, 0,20, 1,0,0,5);
        add(0,1,1,IR_ILL, EN_T1, 0,19, 1,0,0,5);
        add(0,1,1,IR_ILL, EN_T2, 0,21, 1,0,0,5);
        add(0,1,1,IR_ILL, EN0,   0, 0, 1,0,0,5);
        add(0,1,1,IR_ILL, EN0,   0, 0, 1,0,1,5);
        add(0,0,1,IR_ILL, EN0,   0, 0, 1,0,1,5);
        add(0,1,1,IR_ILL, EN0,   0, 0, 1,0,1,5);
        add(1,1,1,IR_ILL, EN0,   0, 0, 0,0,0,0);
        // two SHLs, clear lands in T4 of the second
        add(0,1,1,IR_SHL, EN0,   0, 0, 0,0,0,0);
        add(0,1,1,IR_SHL, EN_T0, 0,20, 0,0,0,0);
        add(0,1,1,IR_SHL, EN_T1, 0,19, 0,0,0,0);
        add(0,1,1,IR_SHL, EN_T2, 0,21, 0,0,0,0);
        add(0,1,1,IR_SHL, EN_T3, 3, 3, 0,0,0,0);
        add(0,1,1,IR_SHL, EN_T4, 4, 4, 6,0,0,0);
        add(0,1,1,IR_SHL, EN_T5A,2,19, 6,0,0,0);
        add(0,1,1,IR_SHL, EN_T0, 0,20, 6,0,0,1);
        add(0,1,1,IR_SHL, EN_T1, 0,19, 6,0,0,1);
        add(0,1,1,IR_SHL, EN_T2, 0,21, 6,0,0,1);
        add(0,1,1,IR_SHL, EN_T3, 3, 3, 6,0,0,1);
        add(0,1,1,IR_SHL, EN_T4, 4, 4, 6,0,0,1);
        add(1,1,1,IR_SHL, EN0,   0, 0, 0,0,0,0);
        add(0,0,1,IR_SHL, EN0,   0, 0, 0,0,0,0);

        repeat (2) @(posedge clock);
        #1;
        foreach (tbl[i]) begin
            clear = tbl[i].clr; run = tbl[i].run; mem_ready = tbl[i].mrdy; IR = tbl[i].ir;
            @(negedge clock);
            chk($sformatf("row%0d", i),
                64'({en_bus, GP_addr, BusDataSelect, ALU_op, halted, fault, instr_count}),
                64'({tbl[i].en, tbl[i].gp, tbl[i].bds, tbl[i].aop, tbl[i].h, tbl[i].f, tbl[i].cnt}));
            @(posedge clock);
            #1;
        end

        // narrow counter: illegal opcodes retire as 4-cycle NOPs, count wraps mod 4
        clear2 = 1'b0; run2 = 1'b1; mem_ready2 = 1'b1; IR2 = IR_ILL;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clock);
            #1;
            if (k == 13) chk("wrap_cnt3", 64'(instr_count2), 64'd3);
            if (k == 17) chk("wrap_cnt0", 64'(instr_count2), 64'd0);
            if (k == 21) chk("wrap_cnt1", 64'(instr_count2), 64'd1);
        end
        chk("nofault_illegal_nop", 64'({fault2, halted2}), 64'd0);
        chk("t0_before_clear", 64'({en2, BusDataSelect2}), 64'({EN_T0, 5'd20}));
        #2 clear2 = 1'b1;
        #1 chk("async_clear", 64'({en2, GP_addr2, BusDataSelect2, ALU_op2, instr_count2}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
